// File: rtl/bellek_denetleyici_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bellek_denetleyici_pkg
// Description : Shared widths, main-memory base address and controller FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bellek_denetleyici_pkg;

  localparam int VERI_BIT  = 32;
  localparam int ADRES_BIT = 32;
  localparam logic [ADRES_BIT-1:0] BELLEK_ADRES = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    OKU_BEKLE = 2'd1,
    YAZ       = 2'd2,
    YANIT     = 2'd3
  } durum_t;

  function automatic logic [ADRES_BIT-1:0] kelime_hizala(input logic [ADRES_BIT-1:0] adres);
    return {adres[ADRES_BIT-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bellek_denetleyici_if.sv
`default_nettype none
// ============================================================================
// Module      : bellek_denetleyici_if
// Description : Core request/response bus plus main-memory port of the
//               memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface bellek_denetleyici_if;
  import bellek_denetleyici_pkg::*;

  logic                 istek_gecerli;
  logic                 istek_hazir;
  logic [ADRES_BIT-1:0] istek_adres;
  logic                 istek_yaz;
  logic [VERI_BIT-1:0]  istek_veri;
  logic                 yanit_gecerli;
  logic [VERI_BIT-1:0]  yanit_veri;
  logic                 yanit_hata;
  logic [ADRES_BIT-1:0] bellek_adres;
  logic [VERI_BIT-1:0]  bellek_oku_veri;
  logic [VERI_BIT-1:0]  bellek_yaz_veri;
  logic                 bellek_yaz;

  // Controller side
  modport slave (
    input  istek_gecerli, istek_adres, istek_yaz, istek_veri, bellek_oku_veri,
    output istek_hazir, yanit_gecerli, yanit_veri, yanit_hata,
           bellek_adres, bellek_yaz_veri, bellek_yaz
  );

  // Core and memory side
  modport master (
    output istek_gecerli, istek_adres, istek_yaz, istek_veri, bellek_oku_veri,
    input  istek_hazir, yanit_gecerli, yanit_veri, yanit_hata,
           bellek_adres, bellek_yaz_veri, bellek_yaz
  );

endinterface
`default_nettype wire

// File: rtl/bellek_denetleyici_bekleme_sayaci.sv
`default_nettype none
// ============================================================================
// Module      : bekleme_sayaci
// Description : Loadable down-counter with a zero flag; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module bekleme_sayaci #(
  parameter int GENISLIK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                yukle,
  input  logic [GENISLIK-1:0] yukle_deger,
  input  logic                azalt,
  output logic                sifir
);

  logic [GENISLIK-1:0] r_sayi;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sayi <= '0;
    end else if (yukle) begin
      r_sayi <= yukle_deger;
    end else if (azalt && (r_sayi != '0)) begin
      r_sayi <= r_sayi - GENISLIK'(1);
    end
  end

  assign sifir = (r_sayi == '0);

endmodule
`default_nettype wire

// File: rtl/bellek_denetleyici.sv
`default_nettype none
// ============================================================================
// Module      : bellek_denetleyici
// Description : Single-outstanding-request controller between core and main
//               memory with fixed read latency. Define BELLEK_ADRES_DENETIM_EN
//               to enable the address range check and yanit_hata reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module bellek_denetleyici
  import bellek_denetleyici_pkg::*;
#(
  parameter int unsigned    BEKLEME_CEVRIM = 2,
  parameter logic [31:0]    BELLEK_BOYUT   = 32'h0001_0000
) (
  input  logic              clk,
  input  logic              rst,
  bellek_denetleyici_if.slave bus
);

  localparam logic [3:0] c_SAYAC_YUKLE = 4'(BEKLEME_CEVRIM - 1);

  if ((BEKLEME_CEVRIM < 1) || (BEKLEME_CEVRIM > 15) || (BELLEK_BOYUT == 32'd0)) begin : g_parametre_denetim
    $error("bellek_denetleyici: BEKLEME_CEVRIM must be 1..15 and BELLEK_BOYUT non-zero");
  end

  durum_t               r_durum;
  durum_t               w_sonraki;
  logic [ADRES_BIT-1:0] r_adres;
  logic [VERI_BIT-1:0]  r_veri;
  logic [VERI_BIT-1:0]  r_yanit_veri;
  logic                 w_hazir;
  logic                 w_kabul;
  logic                 w_adres_hata;
  logic                 w_sayac_yukle;
  logic                 w_sayac_azalt;
  logic                 w_sayac_sifir;
  logic                 w_okuma_bitti;
  logic                 w_yanit_gecerli;
  logic                 w_bellek_yaz;

  assign w_hazir       = (r_durum == BOSTA);
  assign w_kabul       = bus.istek_gecerli & w_hazir;
  assign w_okuma_bitti = (r_durum == OKU_BEKLE) & w_sayac_sifir;

`ifdef BELLEK_ADRES_DENETIM_EN
  logic r_hata;

  assign w_adres_hata = (bus.istek_adres < BELLEK_ADRES) ||
                        ((bus.istek_adres - BELLEK_ADRES) >= BELLEK_BOYUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hata <= 1'b0;
    end else if (w_kabul) begin
      r_hata <= w_adres_hata;
    end
  end

  assign bus.yanit_hata = w_yanit_gecerli & r_hata;
`else
  assign w_adres_hata   = 1'b0;
  assign bus.yanit_hata = 1'b0;
`endif

  bekleme_sayaci #(
    .GENISLIK (4)
  ) u_bekleme_sayaci (
    .clk         (clk),
    .rst         (rst),
    .yukle       (w_sayac_yukle),
    .yukle_deger (c_SAYAC_YUKLE),
    .azalt       (w_sayac_azalt),
    .sifir       (w_sayac_sifir)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_sonraki;
    end
  end

  always_comb begin
    w_sonraki       = r_durum;
    w_sayac_yukle   = 1'b0;
    w_sayac_azalt   = 1'b0;
    w_yanit_gecerli = 1'b0;
    w_bellek_yaz    = 1'b0;
    case (r_durum)
      BOSTA: begin
        if (w_kabul) begin
          // Faulting addresses skip the memory entirely
          if (w_adres_hata) begin
            w_sonraki = YANIT;
          end else if (bus.istek_yaz) begin
            w_sonraki = YAZ;
          end else begin
            w_sonraki     = OKU_BEKLE;
            w_sayac_yukle = 1'b1;
          end
        end
      end
      OKU_BEKLE: begin
        if (w_sayac_sifir) begin
          w_sonraki = YANIT;
        end else begin
          w_sayac_azalt = 1'b1;
        end
      end
      YAZ: begin
        w_bellek_yaz = 1'b1;
        w_sonraki    = YANIT;
      end
      YANIT: begin
        w_yanit_gecerli = 1'b1;
        w_sonraki       = BOSTA;
      end
      default: begin
        w_sonraki = BOSTA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_adres      <= BELLEK_ADRES;
      r_veri       <= '0;
      r_yanit_veri <= '0;
    end else begin
      if (w_kabul) begin
        r_adres <= bus.istek_adres;
        r_veri  <= bus.istek_veri;
      end
      // Read data survives writes and idle cycles until the next read
      if (w_okuma_bitti) begin
        r_yanit_veri <= bus.bellek_oku_veri;
      end
    end
  end

  assign bus.istek_hazir     = w_hazir;
  assign bus.yanit_gecerli   = w_yanit_gecerli;
  assign bus.yanit_veri      = r_yanit_veri;
  assign bus.bellek_adres    = kelime_hizala(r_adres);
  assign bus.bellek_yaz_veri = r_veri;
  assign bus.bellek_yaz      = w_bellek_yaz;

endmodule
`default_nettype wire

// File: tb/tb_bellek_denetleyici.sv
`default_nettype none
// ============================================================================
// Module      : tb_bellek_denetleyici
// Description : Randomised scoreboard bench for bellek_denetleyici with a
//               word-array memory model and latency reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bellek_denetleyici;
  import bellek_denetleyici_pkg::*;

  localparam int          BC    = 2;
  localparam logic [31:0] BOYUT = 32'h0001_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bellek_denetleyici_if bus();

  bellek_denetleyici #(
    .BEKLEME_CEVRIM (BC),
    .BELLEK_BOYUT   (BOYUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] veri;
    logic        hata;
    int          cyc;
  } yanit_t;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] veri;
  } yazma_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  yanit_t      resp_q[$];
  yazma_t      wr_q[$];
  logic [31:0] stub_mem [logic [29:0]];
  logic [31:0] ref_mem  [logic [29:0]];
  logic [31:0] last_read = 32'h0;

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w, 2'b00} ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] ref_oku(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : dflt(a[31:2]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    stub_mem[a[31:2]] = v;
    ref_mem[a[31:2]]  = v;
  endtask

  always @(posedge clk) cyc++;

  // Memory stub and response monitor, sampled on the falling edge
  always @(negedge clk) begin
    yanit_t r;
    yazma_t w;
    if (rst) begin
      if (bus.bellek_yaz) begin
        stub_mem[bus.bellek_adres[31:2]] = bus.bellek_yaz_veri;
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got adr %h data %h, required no write", bus.bellek_adres, bus.bellek_yaz_veri);
        end else begin
          w = wr_q.pop_front();
          check("write_addr", bus.bellek_adres, w.adr);
          check("write_data", bus.bellek_yaz_veri, w.veri);
        end
      end
      if (bus.yanit_gecerli) begin
        if (resp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got pulse at cycle %0d, required none", cyc);
        end else begin
          r = resp_q.pop_front();
          check("resp_data", bus.yanit_veri, r.veri);
          check("resp_fault", 32'(bus.yanit_hata), 32'(r.hata));
          check("resp_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
    bus.bellek_oku_veri = stub_mem.exists(bus.bellek_adres[31:2]) ?
                          stub_mem[bus.bellek_adres[31:2]] : dflt(bus.bellek_adres[31:2]);
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input logic [31:0] a, input logic y, input logic [31:0] d);
    int     t;
    bit     hata;
    yanit_t r;
    t = 0;
    bus.istek_gecerli = 1'b1;
    while (!bus.istek_hazir) begin
      bus.istek_adres = $urandom;
      bus.istek_yaz   = 1'($urandom);
      bus.istek_veri  = $urandom;
      @(negedge clk);
      t++;
      if (t > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got istek_hazir 0 for %0d cycles, required 1", t);
        bus.istek_gecerli = 1'b0;
        return;
      end
    end
    bus.istek_adres = a;
    bus.istek_yaz   = y;
    bus.istek_veri  = d;
`ifdef BELLEK_ADRES_DENETIM_EN
    hata = (longint'(a) < longint'(BELLEK_ADRES)) || (longint'(a) >= longint'(BELLEK_ADRES) + longint'(BOYUT));
`else
    hata = 1'b0;
`endif
    r.hata = hata;
    if (hata) begin
      r.veri = last_read;
      r.cyc  = cyc + 1;
    end else if (y) begin
      ref_mem[a[31:2]] = d;
      wr_q.push_back('{adr: {a[31:2], 2'b00}, veri: d});
      r.veri = last_read;
      r.cyc  = cyc + 2;
    end else begin
      last_read = ref_oku(a);
      r.veri    = last_read;
      r.cyc     = cyc + 1 + BC;
    end
    resp_q.push_back(r);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.istek_gecerli = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.istek_gecerli = 1'b0;
    while (((resp_q.size() != 0) || (wr_q.size() != 0)) && (t < 200)) begin
      @(negedge clk);
      t++;
    end
    if ((resp_q.size() != 0) || (wr_q.size() != 0)) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d responses and %0d writes pending, required 0", resp_q.size(), wr_q.size());
      resp_q.delete();
      wr_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rastgele_adres();
    return BELLEK_ADRES | 32'($urandom_range(0, 63));
  endfunction

  initial begin
    int t;
    bus.istek_gecerli = 1'b0;
    bus.istek_adres   = '0;
    bus.istek_yaz     = 1'b0;
    bus.istek_veri    = '0;

    repeat (2) @(negedge clk);
    check("rst_hazir", 32'(bus.istek_hazir), 32'd1);
    check("rst_yanit_gecerli", 32'(bus.yanit_gecerli), 32'd0);
    check("rst_yanit_hata", 32'(bus.yanit_hata), 32'd0);
    check("rst_yanit_veri", bus.yanit_veri, 32'h0);
    check("rst_bellek_adres", bus.bellek_adres, 32'h8000_0000);
    check("rst_bellek_yaz_veri", bus.bellek_yaz_veri, 32'h0);
    check("rst_bellek_yaz", 32'(bus.bellek_yaz), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    preload(32'h8000_0010, 32'hDEAD_BEEF);
    issue(32'h8000_0010, 1'b0, 32'h0);
    idle(4);
    issue(32'h8000_0020, 1'b1, 32'h1234_5678);
    issue(32'h8000_0020, 1'b0, 32'h0);
    issue(32'h8000_0013, 1'b0, 32'h0);
    check("aligned_addr", bus.bellek_adres, 32'h8000_0010);
    idle(3);

    for (int i = 0; i < 30; i++) begin
      issue(rastgele_adres(), 1'($urandom), $urandom);
    end
    for (int i = 0; i < 30; i++) begin
      issue(rastgele_adres(), 1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
    end
    drain();

    // Reset in the middle of a write
    issue(32'h8000_0040, 1'b1, 32'h1111_2222);
    drain();
    bus.istek_gecerli = 1'b1;
    bus.istek_adres   = 32'h8000_0040;
    bus.istek_yaz     = 1'b1;
    bus.istek_veri    = 32'hCAFE_F00D;
    t = 0;
    while (!bus.istek_hazir && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    check("abort_ready", 32'(bus.istek_hazir), 32'd1);
    @(posedge clk);
    #1;
    bus.istek_gecerli = 1'b0;
    check("abort_yaz_before", 32'(bus.bellek_yaz), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_yaz_dropped", 32'(bus.bellek_yaz), 32'd0);
    check("abort_yanit_gecerli", 32'(bus.yanit_gecerli), 32'd0);
    check("abort_yanit_veri", bus.yanit_veri, 32'h0);
    check("abort_bellek_adres", bus.bellek_adres, 32'h8000_0000);
    check("abort_yaz_veri", bus.bellek_yaz_veri, 32'h0);
    last_read = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("release_hazir", 32'(bus.istek_hazir), 32'd1);
    issue(32'h8000_0044, 1'b1, 32'h5555_AAAA);
    issue(32'h8000_0040, 1'b0, 32'h0);
    drain();

    issue(32'h0000_0100, 1'b1, 32'h0BAD_0BAD);
    issue(BELLEK_ADRES + BOYUT, 1'b0, 32'h0);
    issue(BELLEK_ADRES + BOYUT - 32'd4, 1'b0, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
